wb_interconnect_tag_nx1: RTL and testbench
==========================================

# wb_interconnect_tag_Nx1

Tagged Wishbone N-initiator-to-1-target interconnect: arbitrates N tagged Wishbone initiators onto one shared tagged target port and routes the response back to the owning initiator. It sits upstream of a 1xN address-decoding interconnect, so several masters (CPU, DMA, debug) can share one decoded bus. Arbitration is round-robin with a registered grant held for a whole Wishbone cycle (`cyc`), plus an optional no-response timeout that terminates a stalled access with `err`.

## Interface
- ADR_WIDTH, 32, address width
- DAT_WIDTH, 32, data width; select width is DAT_WIDTH/8
- TGA_WIDTH, 4, address-tag width
- TGD_WIDTH, 4, data-tag width (write and read)
- TGC_WIDTH, 4, cycle-tag width
- N_INITIATORS, 2, number of initiators (≥1)
- TIMEOUT, 0, timeout in cycles for stb-without-ack/err; 0 disables
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- t_adr  in  N*ADR_WIDTH  per-initiator address (t_ = target ports into interconnect, one slice per initiator)
- t_dat_w  in  N*DAT_WIDTH  write data
- t_dat_r  out  DAT_WIDTH  read data, broadcast to all initiators
- t_cyc, t_stb, t_we  in  N  cycle, strobe, write enable
- t_sel  in  N*DAT_WIDTH/8  byte selects
- t_tga  in  N*TGA_WIDTH; t_tgc  in  N*TGC_WIDTH; t_tgd_w  in  N*TGD_WIDTH  tags
- t_tgd_r  out  TGD_WIDTH  read data tag, broadcast
- t_ack, t_err  out  N  per-initiator termination
- i_adr, i_dat_w, i_sel, i_we, i_tga, i_tgc, i_tgd_w  out  scalar widths  initiator port out to target
- i_cyc, i_stb  out  1
- i_dat_r, i_tgd_r, i_ack, i_err  in  scalar widths  target response

## Operation
- States: IDLE (no owner), OWNED (gnt holds owner index).
- IDLE: if any t_cyc set, pick the first requester in round-robin order starting at last_gnt+1 (mod N); register gnt and go to OWNED. No request: stay.
- OWNED: i_cyc=t_cyc[gnt], i_stb=t_stb[gnt]; all forward signals muxed from slice gnt. t_ack[gnt]=i_ack, t_err[gnt]=i_err; all other t_ack/t_err are 0.
- Release: owner drops t_cyc → that cycle i_cyc=0; last_gnt←gnt; arbitrate as in IDLE in the same cycle (excluding nobody; the owner wins again only if no other requester and it reasserts cyc).
- A grant is never revoked while owner's t_cyc=1 (block/RMW cycles are preserved).
- Timeout (TIMEOUT>0): counter clears when i_stb=0, i_ack or i_err. Otherwise it increments while i_cyc&i_stb. At TIMEOUT-1: t_err[gnt]=1 for that cycle, i_stb forced 0 that cycle, counter cleared. Counter width is $clog2(TIMEOUT+1).
- In IDLE, forward data signals are driven from slice last_gnt. i_cyc and i_stb are 0.

## Timing
- Reset: state=IDLE, last_gnt=N-1 (so initiator 0 has first priority), counter=0. i_cyc=i_stb=0, t_ack=t_err=0.
- Arbitration latency: t_cyc rising at cycle k while idle → i_cyc=1 at k+1.
- Response path is combinational: i_ack→t_ack in the same cycle, with no added wait states after grant.
- Handoff: one dead cycle (i_cyc=0) between owners.
- Simultaneous requests: resolved strictly by round-robin pointer.
- Reset during OWNED: grant dropped next edge; any in-flight access is abandoned; i_cyc=0 after the edge.
- N_INITIATORS=1: gnt is constant 0; one-cycle arbitration latency is still present.

## Structure
- Shared package wb_interconnect_pkg: state encoding (IDLE/OWNED), $clog2-based index-width helper.
- Sub-module wb_rr_arbiter (N, req vector, last_gnt in, gnt index/valid out), combinational; state and pointer registers live in the top.
- Header wishbone_tag_macros.svh supplies port macros (target-array and initiator forms).

## Test plan
- N=2, initiator 0 single write adr 'h2800_0010, data 'hDEADBEEF, tga=3 → i_cyc at +1 cycle, i_adr/i_dat_w/i_tga match, t_ack[0] same cycle as i_ack, t_ack[1]=0.
- Both assert cyc in the same cycle after reset → initiator 0 served first. Then one dead cycle, then initiator 1. Repeat → order alternates 1,0.
- Initiator 1 holds cyc for a 4-beat read burst while initiator 0 requests → no switch until t_cyc[1] drops. t_dat_r and t_tgd_r equal i_dat_r/i_tgd_r each beat.
- TIMEOUT=8, target never acks → t_err[gnt]=1 exactly at the 8th stb cycle with i_stb=0 that cycle. Counter restarts if stb is held.
- Reset asserted mid-access (OWNED, stb=1) → i_cyc=0, t_ack=t_err=0 after the edge. Next request granted to initiator 0.
- Target returns i_err → routed only to owner's t_err. Grant is retained until the owner drops cyc.

Source files
------------

// File: rtl/wb_interconnect_pkg.sv
// Shared definitions for the tagged Wishbone Nx1 interconnect:
// arbitration state encoding and the grant-index width helper.
package wb_interconnect_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Width of an index into n initiators; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: scans requests starting one past the
// previous grant and returns the first requester found.
module wb_rr_arbiter
  import wb_interconnect_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_gnt,
  output logic [IDX_W-1:0] o_gnt,
  output logic             o_valid
);

  // Walk the N positions after i_last_gnt (wrapping) and keep the first hit.
  always_comb begin
    o_valid = 1'b0;
    o_gnt   = i_last_gnt;
    for (int k = 1; k <= N; k++) begin
      logic [IDX_W-1:0] w_idx;
      logic             w_hit;
      w_idx   = IDX_W'((int'(i_last_gnt) + k) % N);
      w_hit   = !o_valid && i_req[w_idx];
      o_gnt   = w_hit ? w_idx : o_gnt;
      o_valid = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/wb_interconnect_tag_nx1.sv
// Tagged Wishbone N-initiator to 1-target interconnect. A registered
// round-robin grant is held for a whole cyc; the response path back to the
// owner is combinational. An optional watchdog ends a stalled strobe with err.
module wb_interconnect_tag_nx1
  import wb_interconnect_pkg::*;
#(
  parameter int ADR_WIDTH    = 32,
  parameter int DAT_WIDTH    = 32,
  parameter int TGA_WIDTH    = 4,
  parameter int TGD_WIDTH    = 4,
  parameter int TGC_WIDTH    = 4,
  parameter int N_INITIATORS = 2,
  parameter int TIMEOUT      = 0
) (
  input  logic                                    clock,
  input  logic                                    reset,
  // initiator-facing slices, one per initiator
  input  logic [N_INITIATORS*ADR_WIDTH-1:0]       t_adr,
  input  logic [N_INITIATORS*DAT_WIDTH-1:0]       t_dat_w,
  output logic [DAT_WIDTH-1:0]                    t_dat_r,
  input  logic [N_INITIATORS-1:0]                 t_cyc,
  input  logic [N_INITIATORS-1:0]                 t_stb,
  input  logic [N_INITIATORS-1:0]                 t_we,
  input  logic [N_INITIATORS*(DAT_WIDTH/8)-1:0]   t_sel,
  input  logic [N_INITIATORS*TGA_WIDTH-1:0]       t_tga,
  input  logic [N_INITIATORS*TGC_WIDTH-1:0]       t_tgc,
  input  logic [N_INITIATORS*TGD_WIDTH-1:0]       t_tgd_w,
  output logic [TGD_WIDTH-1:0]                    t_tgd_r,
  output logic [N_INITIATORS-1:0]                 t_ack,
  output logic [N_INITIATORS-1:0]                 t_err,
  // shared port towards the target
  output logic [ADR_WIDTH-1:0]                    i_adr,
  output logic [DAT_WIDTH-1:0]                    i_dat_w,
  output logic [DAT_WIDTH/8-1:0]                  i_sel,
  output logic                                    i_we,
  output logic [TGA_WIDTH-1:0]                    i_tga,
  output logic [TGC_WIDTH-1:0]                    i_tgc,
  output logic [TGD_WIDTH-1:0]                    i_tgd_w,
  output logic                                    i_cyc,
  output logic                                    i_stb,
  input  logic [DAT_WIDTH-1:0]                    i_dat_r,
  input  logic [TGD_WIDTH-1:0]                    i_tgd_r,
  input  logic                                    i_ack,
  input  logic                                    i_err
);

  localparam int  IDX_W   = idx_width(N_INITIATORS);
  localparam int  SEL_W   = DAT_WIDTH / 8;
  localparam bit  TO_EN   = (TIMEOUT > 0);
  localparam int  CNT_W   = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam int  TO_LAST = TO_EN ? (TIMEOUT - 1) : 0;

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_gnt;
  logic [IDX_W-1:0] r_last_gnt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_owned;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_ptr;
  logic [IDX_W-1:0] w_arb_gnt;
  logic             w_arb_valid;
  logic             w_cyc_raw;
  logic             w_stb_raw;
  logic             w_active;
  logic             w_timeout;
  logic             w_cnt_clr;

  assign w_owned   = (r_state == ST_OWNED);
  // Forward mux follows the owner; while idle it parks on the last owner.
  assign w_idx     = w_owned ? r_gnt : r_last_gnt;
  // On release the departing owner is the round-robin reference point.
  assign w_ptr     = w_owned ? r_gnt : r_last_gnt;
  assign w_cyc_raw = t_cyc[r_gnt];
  assign w_stb_raw = t_stb[r_gnt];
  assign w_active  = w_owned && w_cyc_raw && w_stb_raw;
  assign w_timeout = TO_EN && w_active && !i_ack && !i_err &&
                     (r_cnt == CNT_W'(TO_LAST));
  assign w_cnt_clr = !TO_EN || !w_active || i_ack || i_err || w_timeout;

  wb_rr_arbiter #(
    .N (N_INITIATORS)
  ) u_arb (
    .i_req      (t_cyc),
    .i_last_gnt (w_ptr),
    .o_gnt      (w_arb_gnt),
    .o_valid    (w_arb_valid)
  );

  // Grant FSM, round-robin pointer and no-response watchdog counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_last_gnt <= IDX_W'(N_INITIATORS - 1);
      r_cnt      <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : (r_cnt + CNT_W'(1));
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_gnt   <= w_arb_gnt;
            r_state <= ST_OWNED;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_OWNED: begin
          if (!w_cyc_raw) begin
            // Owner released: re-arbitrate in the same cycle.
            r_last_gnt <= r_gnt;
            if (w_arb_valid) begin
              r_gnt   <= w_arb_gnt;
              r_state <= ST_OWNED;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_OWNED;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Forward path: select the active slice and gate cyc/stb by ownership.
  always_comb begin
    i_adr   = t_adr[w_idx*ADR_WIDTH +: ADR_WIDTH];
    i_dat_w = t_dat_w[w_idx*DAT_WIDTH +: DAT_WIDTH];
    i_sel   = t_sel[w_idx*SEL_W +: SEL_W];
    i_we    = t_we[w_idx];
    i_tga   = t_tga[w_idx*TGA_WIDTH +: TGA_WIDTH];
    i_tgc   = t_tgc[w_idx*TGC_WIDTH +: TGC_WIDTH];
    i_tgd_w = t_tgd_w[w_idx*TGD_WIDTH +: TGD_WIDTH];
    i_cyc   = w_owned && w_cyc_raw;
    i_stb   = w_active && !w_timeout;
  end

  // Response path: read data broadcast, terminations steered to the owner.
  always_comb begin
    t_dat_r = i_dat_r;
    t_tgd_r = i_tgd_r;
    t_ack   = '0;
    t_err   = '0;
    if (w_owned) begin
      t_ack[r_gnt] = i_ack;
      t_err[r_gnt] = i_err || w_timeout;
    end else begin
      t_ack = '0;
      t_err = '0;
    end
  end

endmodule

// File: tb/tb_wb_interconnect_tag_nx1.sv
// Directed bench for wb_interconnect_tag_nx1 with two initiators and an
// eight-cycle watchdog. Inputs change 1ns after the rising edge, outputs are
// checked at the falling edge (or 1ns later after a response input change).
module tb_wb_interconnect_tag_nx1;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] t_adr, t_dat_w;
  logic [31:0] t_dat_r;
  logic [1:0]  t_cyc, t_stb, t_we, t_ack, t_err;
  logic [7:0]  t_sel, t_tga, t_tgc, t_tgd_w;
  logic [3:0]  t_tgd_r;
  logic [31:0] i_adr, i_dat_w, i_dat_r;
  logic [3:0]  i_sel, i_tga, i_tgc, i_tgd_w, i_tgd_r;
  logic        i_we, i_cyc, i_stb, i_ack, i_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  wb_interconnect_tag_nx1 #(
    .ADR_WIDTH(32), .DAT_WIDTH(32), .TGA_WIDTH(4), .TGD_WIDTH(4),
    .TGC_WIDTH(4), .N_INITIATORS(2), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel),
    .t_tga(t_tga), .t_tgc(t_tgc), .t_tgd_w(t_tgd_w), .t_tgd_r(t_tgd_r),
    .t_ack(t_ack), .t_err(t_err),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
    .i_tga(i_tga), .i_tgc(i_tgc), .i_tgd_w(i_tgd_w),
    .i_cyc(i_cyc), .i_stb(i_stb),
    .i_dat_r(i_dat_r), .i_tgd_r(i_tgd_r), .i_ack(i_ack), .i_err(i_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic mid;
    #4;
  endtask

  task automatic set_req(input int n, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] tga);
    t_cyc[n]            = cyc;
    t_stb[n]            = stb;
    t_we[n]             = we;
    t_adr[n*32 +: 32]   = adr;
    t_dat_w[n*32 +: 32] = dat;
    t_tga[n*4 +: 4]     = tga;
    t_sel[n*4 +: 4]     = 4'hF;
    t_tgc[n*4 +: 4]     = 4'h0;
    t_tgd_w[n*4 +: 4]   = tga;
  endtask

  initial begin
    reset   = 1'b1;
    t_adr   = 64'h0; t_dat_w = 64'h0;
    t_cyc   = 2'b00; t_stb = 2'b00; t_we = 2'b00;
    t_sel   = 8'h00; t_tga = 8'h00; t_tgc = 8'h00; t_tgd_w = 8'h00;
    i_dat_r = 32'h0; i_tgd_r = 4'h0; i_ack = 1'b1; i_err = 1'b0;

    // Reset state: nothing forwarded, a stray target ack reaches nobody.
    repeat (2) next_cycle();
    mid();
    check("rst_cyc", 64'(i_cyc), 64'h0);
    check("rst_stb", 64'(i_stb), 64'h0);
    check("rst_ack", 64'(t_ack), 64'h0);
    check("rst_err", 64'(t_err), 64'h0);

    // Single write from initiator 0.
    next_cycle();
    reset = 1'b0; i_ack = 1'b0;
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h2800_0010, 32'hDEAD_BEEF, 4'h3);
    mid();
    check("wr_latency", 64'(i_cyc), 64'h0);
    next_cycle();
    mid();
    check("wr_cyc", 64'(i_cyc), 64'h1);
    check("wr_stb", 64'(i_stb), 64'h1);
    check("wr_adr", 64'(i_adr), 64'h2800_0010);
    check("wr_dat", 64'(i_dat_w), 64'hDEAD_BEEF);
    check("wr_tga", 64'(i_tga), 64'h3);
    check("wr_we", 64'(i_we), 64'h1);
    check("wr_noack", 64'(t_ack), 64'h0);
    i_ack = 1'b1;
    #1;
    check("wr_ack", 64'(t_ack), 64'h1);
    next_cycle();
    i_ack = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h2800_0010, 32'hDEAD_BEEF, 4'h3);
    mid();
    check("wr_release", 64'(i_cyc), 64'h0);

    // Simultaneous requests right after reset: 0 first, then 1.
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h1);
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h2);
    mid();
    check("both_lat", 64'(i_cyc), 64'h0);
    next_cycle();
    mid();
    check("both_first_cyc", 64'(i_cyc), 64'h1);
    check("both_first_adr", 64'(i_adr), 64'h100);
    check("both_first_tga", 64'(i_tga), 64'h1);
    i_ack = 1'b1;
    #1;
    check("both_first_ack", 64'(t_ack), 64'h1);
    next_cycle();
    i_ack = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h1);
    mid();
    check("dead1_cyc", 64'(i_cyc), 64'h0);
    check("dead1_ack", 64'(t_ack), 64'h0);
    next_cycle();
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h1);
    mid();
    check("second_cyc", 64'(i_cyc), 64'h1);
    check("second_adr", 64'(i_adr), 64'h200);
    i_ack = 1'b1;
    #1;
    check("second_ack", 64'(t_ack), 64'h2);
    next_cycle();
    i_ack = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h2);
    mid();
    check("dead2_cyc", 64'(i_cyc), 64'h0);
    next_cycle();
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h2);
    mid();
    check("third_adr", 64'(i_adr), 64'h104);
    check("third_cyc", 64'(i_cyc), 64'h1);
    next_cycle();
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h1);
    mid();
    check("dead3_cyc", 64'(i_cyc), 64'h0);

    // Four-beat read burst by initiator 1 while initiator 0 waits.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 0) set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h5);
      i_dat_r = 32'hA000_0000 + 32'(k);
      i_tgd_r = 4'(k + 4);
      i_ack   = 1'b1;
      mid();
      check("burst_cyc", 64'(i_cyc), 64'h1);
      check("burst_adr", 64'(i_adr), 64'h204);
      check("burst_dat", 64'(t_dat_r), 64'hA000_0000 + 64'(k));
      check("burst_tgd", 64'(t_tgd_r), 64'(k + 4));
      check("burst_ack", 64'(t_ack), 64'h2);
    end
    next_cycle();
    i_ack = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0000_0204, 32'h0, 4'h2);
    mid();
    check("burst_release", 64'(i_cyc), 64'h0);

    // Target error goes only to the owner; grant survives it.
    next_cycle();
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h0000_020C, 32'h0, 4'h2);
    mid();
    check("err_owner_adr", 64'(i_adr), 64'h108);
    i_err = 1'b1;
    #1;
    check("err_route", 64'(t_err), 64'h1);
    check("err_noack", 64'(t_ack), 64'h0);
    next_cycle();
    i_err = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h5);
    mid();
    check("err_hold_cyc", 64'(i_cyc), 64'h1);
    check("err_hold_stb", 64'(i_stb), 64'h0);
    check("err_hold_adr", 64'(i_adr), 64'h108);
    check("err_clear", 64'(t_err), 64'h0);

    // Watchdog: no ack for 16 strobe cycles -> err on the 8th and 16th.
    for (int c = 0; c < 16; c++) begin
      next_cycle();
      if (c == 0) set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h5);
      mid();
      check("to_err", 64'(t_err), ((c % 8) == 7) ? 64'h1 : 64'h0);
      check("to_stb", 64'(i_stb), ((c % 8) == 7) ? 64'h0 : 64'h1);
    end

    // Reset in the middle of an owned access.
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    i_ack = 1'b1;
    mid();
    check("rst_mid_cyc", 64'(i_cyc), 64'h0);
    check("rst_mid_stb", 64'(i_stb), 64'h0);
    check("rst_mid_ack", 64'(t_ack), 64'h0);
    check("rst_mid_err", 64'(t_err), 64'h0);
    next_cycle();
    i_ack = 1'b0;
    mid();
    check("rst_regrant_cyc", 64'(i_cyc), 64'h1);
    check("rst_regrant_adr", 64'(i_adr), 64'h108);
    next_cycle();
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mid();
    check("final_release", 64'(i_cyc), 64'h0);
    repeat (2) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
